// File: rtl/riscv_decode_pkg.sv
// Shared RV32I decode definitions: opcode values, instruction formats,
// buffer occupancy states and the decoded-field bundle.
package riscv_decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // The immediate is carried separately because its width follows XLEN.
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    fmt_e       fmt;
    logic       illegal;
  } decoded_t;

endpackage

// File: rtl/riscv_decode_comb.sv
// Purely combinational RV32I field extraction, immediate generation and
// illegal-encoding detection.
module riscv_decode_comb
  import riscv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output decoded_t        dec,
  output logic [XLEN-1:0] imm
);

  logic [31:0] raw;
  logic [2:0]  f3;
  logic [6:0]  f7;

  assign f3 = instr[14:12];
  assign f7 = instr[31:25];

  always_comb begin
    raw        = '0;
    dec        = '0;
    dec.opcode = instr[6:0];
    case (instr[6:0])
      OP_R: begin
        dec.fmt     = FMT_R;
        dec.funct3  = f3;
        dec.funct7  = f7;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.rd      = instr[11:7];
        dec.illegal = (f7 != 7'b0000000 && f7 != 7'b0100000) ||
                      (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101);
      end
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: begin
        dec.fmt     = FMT_I;
        dec.funct3  = f3;
        dec.rs1     = instr[19:15];
        dec.rd      = instr[11:7];
        raw         = {{20{instr[31]}}, instr[31:20]};
        dec.illegal = (instr[6:0] == OP_JALR && f3 != 3'b000) ||
                      (instr[6:0] == OP_LOAD && (f3 == 3'b011 || f3[2:1] == 2'b11));
      end
      OP_STORE: begin
        dec.fmt     = FMT_S;
        dec.funct3  = f3;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        raw         = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        dec.illegal = (f3 > 3'b010);
      end
      OP_BRANCH: begin
        dec.fmt     = FMT_B;
        dec.funct3  = f3;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        raw         = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        dec.illegal = (f3 == 3'b010 || f3 == 3'b011);
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt = FMT_U;
        dec.rd  = instr[11:7];
        raw     = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        dec.rd  = instr[11:7];
        raw     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: dec.illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) dec.illegal = 1'b1;
    // Illegal entries keep only the opcode so execute sees clean zeros.
    if (dec.illegal) begin
      dec         = '0;
      dec.opcode  = instr[6:0];
      dec.illegal = 1'b1;
      raw         = '0;
    end
  end

  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/riscv_decode_stage.sv
// Registered RV32I decode stage: combinational decode feeding a FIFO-ordered
// skid buffer so that back-pressure never reaches fetch combinationally.
module riscv_decode_stage
  import riscv_decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SKID_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    decoded_t        dec;
  } entry_t;

  decoded_t        dec_w;
  logic [XLEN-1:0] imm_w;
  entry_t          in_entry;
  entry_t          head, head_n, tail, tail_n;
  occ_e            occ, occ_n;
  logic            ready_q;
  logic            push, pop;

  riscv_decode_comb #(.XLEN(XLEN)) u_decode (
    .instr (in_instr),
    .dec   (dec_w),
    .imm   (imm_w)
  );

  assign in_entry = {in_pc, imm_w, dec_w};
  assign push     = in_valid && in_ready && !flush;
  assign pop      = out_valid && out_ready;

  // head is always the oldest entry; tail only holds data in OCC_TWO.
  always_comb begin
    occ_n  = occ;
    head_n = head;
    tail_n = tail;
    if (flush) begin
      occ_n = OCC_EMPTY;
    end else begin
      case (occ)
        OCC_EMPTY: if (push) begin
          head_n = in_entry;
          occ_n  = OCC_ONE;
        end
        OCC_ONE: begin
          if (push && pop) begin
            head_n = in_entry;
          end else if (push) begin
            tail_n = in_entry;
            occ_n  = OCC_TWO;
          end else if (pop) begin
            occ_n = OCC_EMPTY;
          end
        end
        OCC_TWO: if (pop) begin
          head_n = tail;
          occ_n  = OCC_ONE;
        end
        default: occ_n = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ     <= OCC_EMPTY;
      head    <= '0;
      tail    <= '0;
      ready_q <= 1'b1;
    end else begin
      occ     <= occ_n;
      head    <= head_n;
      tail    <= tail_n;
      ready_q <= (occ_n != OCC_TWO);
    end
  end

  // A single-entry buffer can only refill in the cycle it drains.
  assign in_ready = (SKID_DEPTH == 1) ? (occ == OCC_EMPTY || out_ready) : ready_q;

  assign out_valid   = (occ != OCC_EMPTY);
  assign out_pc      = head.pc;
  assign out_imm     = head.imm;
  assign out_opcode  = head.dec.opcode;
  assign out_funct3  = head.dec.funct3;
  assign out_funct7  = head.dec.funct7;
  assign out_rs1     = head.dec.rs1;
  assign out_rs2     = head.dec.rs2;
  assign out_rd      = head.dec.rd;
  assign out_fmt     = head.dec.fmt;
  assign out_illegal = head.dec.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Drives XLEN=32 and XLEN=64 decode stages in lockstep and checks both
// against a FIFO scoreboard and an arithmetic RV32I decode model.
module tb_riscv_decode_stage;
  import riscv_decode_pkg::*;

  logic        clk, rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [31:0] pc32;
  logic [63:0] pc64;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] out_pc32, imm32;
  logic [6:0]  opc32, f7_32;
  logic [2:0]  f3_32, fmt32;
  logic [4:0]  rs1_32, rs2_32, rd32;

  logic        in_ready64, out_valid64, ill64;
  logic [63:0] out_pc64, imm64;
  logic [6:0]  opc64, f7_64;
  logic [2:0]  f3_64, fmt64;
  logic [4:0]  rs1_64, rs2_64, rd64;

  riscv_decode_stage #(.XLEN(32), .SKID_DEPTH(2)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(pc32), .out_valid(out_valid32), .out_ready(out_ready),
    .out_pc(out_pc32), .out_opcode(opc32), .out_funct3(f3_32), .out_funct7(f7_32),
    .out_rs1(rs1_32), .out_rs2(rs2_32), .out_rd(rd32), .out_imm(imm32),
    .out_fmt(fmt32), .out_illegal(ill32)
  );

  riscv_decode_stage #(.XLEN(64), .SKID_DEPTH(2)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(pc64), .out_valid(out_valid64), .out_ready(out_ready),
    .out_pc(out_pc64), .out_opcode(opc64), .out_funct3(f3_64), .out_funct7(f7_64),
    .out_rs1(rs1_64), .out_rs2(rs2_64), .out_rd(rd64), .out_imm(imm64),
    .out_fmt(fmt64), .out_illegal(ill64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } txn_t;

  typedef struct {
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] fmt;
    logic       illegal;
    longint     imm;
  } exp_t;

  txn_t q[$];
  logic ready_model;
  int   n_checks = 0;
  int   n_fails  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode: immediates rebuilt by signed shifts and weighted sums.
  function automatic exp_t refDecode(input logic [31:0] w);
    exp_t       e;
    longint     sw;
    byte        kind;
    logic       bad;
    logic [2:0] f3;
    logic [6:0] f7;
    f3   = w[14:12];
    f7   = w[31:25];
    sw   = longint'($signed(w));
    e    = '{default: '0};
    bad  = 1'b0;
    kind = "X";
    e.opcode = w[6:0];
    case (w[6:0])
      OP_R:                                         kind = "R";
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: kind = "I";
      OP_STORE:                                     kind = "S";
      OP_BRANCH:                                    kind = "B";
      OP_LUI, OP_AUIPC:                             kind = "U";
      OP_JAL:                                       kind = "J";
      default:                                      bad = 1'b1;
    endcase
    if (w[1:0] != 2'b11) bad = 1'b1;
    if (kind == "R" && !(f7 inside {7'h00, 7'h20})) bad = 1'b1;
    if (kind == "R" && f7 == 7'h20 && !(f3 inside {3'd0, 3'd5})) bad = 1'b1;
    if (w[6:0] == OP_JALR && f3 != 3'd0) bad = 1'b1;
    if (w[6:0] == OP_BRANCH && f3 inside {3'd2, 3'd3}) bad = 1'b1;
    if (w[6:0] == OP_LOAD && f3 inside {3'd3, 3'd6, 3'd7}) bad = 1'b1;
    if (w[6:0] == OP_STORE && f3 > 3'd2) bad = 1'b1;
    if (bad) begin
      e.illegal = 1'b1;
      return e;
    end
    case (kind)
      "R": begin e.fmt = FMT_R; e.f3 = f3; e.f7 = f7; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; end
      "I": begin e.fmt = FMT_I; e.f3 = f3; e.rs1 = w[19:15]; e.rd = w[11:7]; e.imm = sw >>> 20; end
      "S": begin
        e.fmt = FMT_S; e.f3 = f3; e.rs1 = w[19:15]; e.rs2 = w[24:20];
        e.imm = (sw >>> 25) * 32 + longint'(w[11:7]);
      end
      "B": begin
        e.fmt = FMT_B; e.f3 = f3; e.rs1 = w[19:15]; e.rs2 = w[24:20];
        e.imm = (sw >>> 31) * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
      end
      "U": begin e.fmt = FMT_U; e.rd = w[11:7]; e.imm = (sw >>> 12) * 4096; end
      default: begin
        e.fmt = FMT_J; e.rd = w[11:7];
        e.imm = (sw >>> 31) * 1048576 + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
      end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] w;
    logic [6:0]  ops [0:10];
    ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM, OP_FENCE};
    w = $urandom;
    if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 10)];
    if (w[6:0] == OP_R && $urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic compareAll();
    exp_t e;
    checkOutput("valid32", 64'(out_valid32), 64'(q.size() != 0));
    checkOutput("valid64", 64'(out_valid64), 64'(q.size() != 0));
    checkOutput("ready32", 64'(in_ready32), 64'(ready_model));
    checkOutput("ready64", 64'(in_ready64), 64'(ready_model));
    if (q.size() != 0) begin
      e = refDecode(q[0].instr);
      checkOutput("pc32", 64'(out_pc32), 64'(q[0].pc[31:0]));
      checkOutput("pc64", out_pc64, q[0].pc);
      checkOutput("fields32", 64'({opc32, f3_32, f7_32, rs1_32, rs2_32, rd32, fmt32, ill32}),
                  64'({e.opcode, e.f3, e.f7, e.rs1, e.rs2, e.rd, e.fmt, e.illegal}));
      checkOutput("fields64", 64'({opc64, f3_64, f7_64, rs1_64, rs2_64, rd64, fmt64, ill64}),
                  64'({e.opcode, e.f3, e.f7, e.rs1, e.rs2, e.rd, e.fmt, e.illegal}));
      checkOutput("imm32", 64'(imm32), 64'(e.imm[31:0]));
      checkOutput("imm64", imm64, 64'(e.imm));
    end
  endtask

  // One clock of stimulus: check pre-edge outputs, advance the model, clock.
  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [63:0] pc,
                               input logic rdy, input logic fl);
    txn_t t;
    logic pop, push;
    in_valid  = v;
    in_instr  = instr;
    pc64      = pc;
    pc32      = pc[31:0];
    out_ready = rdy;
    flush     = fl;
    compareAll();
    pop  = (q.size() != 0) && rdy;
    push = v && ready_model && !fl;
    t.instr = instr;
    t.pc    = pc;
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(t);
    end
    ready_model = (q.size() < 2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; pc32 = '0; pc64 = '0;
    ready_model = 1'b1;
    #1 rst = 1'b1;
    #2;
    compareAll();
    checkOutput("rst_pc64", out_pc64, 64'd0);
    checkOutput("rst_imm64", imm64, 64'd0);
    checkOutput("rst_rd32", 64'(rd32), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // addi x1,x0,-1
    applyStimulus(1'b1, 32'hFFF00093, 64'h0000_0000_0000_1000, 1'b1, 1'b0);
    checkOutput("addi_valid", 64'(out_valid32), 64'd1);
    checkOutput("addi_rd", 64'(rd32), 64'd1);
    checkOutput("addi_rs1", 64'(rs1_32), 64'd0);
    checkOutput("addi_imm32", 64'(imm32), 64'h0000_0000_FFFF_FFFF);
    checkOutput("addi_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("addi_fmt", 64'(fmt64), 64'(FMT_I));
    checkOutput("addi_ill", 64'(ill32), 64'd0);
    // beq x1,x2,-4
    applyStimulus(1'b1, 32'hFE208EE3, 64'h0000_0000_0000_1004, 1'b1, 1'b0);
    checkOutput("beq_rs1", 64'(rs1_32), 64'd1);
    checkOutput("beq_rs2", 64'(rs2_32), 64'd2);
    checkOutput("beq_rd", 64'(rd32), 64'd0);
    checkOutput("beq_imm", 64'(imm32), 64'h0000_0000_FFFF_FFFC);
    checkOutput("beq_fmt", 64'(fmt32), 64'(FMT_B));
    // lui x5,0x12345
    applyStimulus(1'b1, 32'h123452B7, 64'h0000_0000_0000_1008, 1'b1, 1'b0);
    checkOutput("lui_rd", 64'(rd32), 64'd5);
    checkOutput("lui_imm", imm64, 64'h0000_0000_1234_5000);
    // jal x1,+8
    applyStimulus(1'b1, 32'h008000EF, 64'h0000_0000_0000_100C, 1'b1, 1'b0);
    checkOutput("jal_rd", 64'(rd32), 64'd1);
    checkOutput("jal_imm", 64'(imm32), 64'd8);
    checkOutput("jal_fmt", 64'(fmt32), 64'(FMT_J));
    // Illegal encodings
    applyStimulus(1'b1, 32'h00000000, 64'h0000_0000_0000_2000, 1'b1, 1'b0);
    checkOutput("ill0_flag", 64'(ill32), 64'd1);
    applyStimulus(1'b1, 32'hFFFFFFFF, 64'h0000_0000_0000_2004, 1'b1, 1'b0);
    checkOutput("illF_flag", 64'(ill64), 64'd1);
    checkOutput("illF_rd_rs1", 64'({rd64, rs1_64}), 64'd0);
    checkOutput("illF_imm", imm64, 64'd0);
    applyStimulus(1'b1, 32'h40001033, 64'h0000_0000_0000_2008, 1'b1, 1'b0);
    checkOutput("illsub_flag", 64'(ill32), 64'd1);
    checkOutput("illsub_regs", 64'({rd32, rs1_32, rs2_32}), 64'd0);
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // Back-pressure: A, B accepted, C held until space frees
    applyStimulus(1'b1, 32'h00100093, 64'h0000_00AA_0000_3000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00200113, 64'h0000_00BB_0000_3004, 1'b0, 1'b0);
    checkOutput("bp_ready_low", 64'(in_ready32), 64'd0);
    applyStimulus(1'b1, 32'h00300193, 64'h0000_00CC_0000_3008, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00300193, 64'h0000_00CC_0000_3008, 1'b1, 1'b0);
    checkOutput("bp_order_B", out_pc64, 64'h0000_00BB_0000_3004);
    applyStimulus(1'b1, 32'h00300193, 64'h0000_00CC_0000_3008, 1'b1, 1'b0);
    checkOutput("bp_order_C", out_pc64, 64'h0000_00CC_0000_3008);
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("bp_drained", 64'(out_valid64), 64'd0);

    // Flush with the buffer full and fetch still presenting
    applyStimulus(1'b1, 32'h00400213, 64'h0000_0000_0000_4000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00500293, 64'h0000_0000_0000_4004, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00600313, 64'h0000_0000_0000_4008, 1'b1, 1'b1);
    checkOutput("flush_valid", 64'(out_valid32), 64'd0);
    checkOutput("flush_ready", 64'(in_ready32), 64'd1);
    applyStimulus(1'b1, 32'h00700393, 64'h0000_0000_0000_400C, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00800413, 64'h0000_0000_0000_4010, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges
    applyStimulus(1'b1, 32'h00900493, 64'h0000_0000_0000_5000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00A00513, 64'h0000_0000_0000_5004, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_valid32", 64'(out_valid32), 64'd0);
    checkOutput("arst_valid64", 64'(out_valid64), 64'd0);
    checkOutput("arst_ready", 64'(in_ready64), 64'd1);
    q.delete();
    ready_model = 1'b1;
    #1 rst = 1'b0;

    // Random traffic against the scoreboard
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), randInstr(), {$urandom, $urandom},
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
